onehot_request_latch: RTL



---
 rtl/onehot_request_latch_if.sv | 34 +++
 rtl/onehot_request_latch.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/onehot_request_latch_if.sv
// rtl/onehot_request_latch_if.sv - request bus between the key front end and the 8-to-3 encoder
//
// Signals:
//   key_in     raw active-high key lines into the front end
//   onehot_out held one-hot request (bit i feeds encoder input i), zero when idle
//   valid      high while onehot_out carries a request
//   ack        consumer acknowledge, only meaningful while valid=1
//   miss       one-cycle pulse: a key press was debounced while a request was outstanding
// Modports:
//   master     the request latch (consumes key_in/ack, drives the request)
//   slave      keys plus consumer side (drives key_in/ack, observes the request)
interface onehot_request_latch_if;
  logic [7:0] key_in;
  logic [7:0] onehot_out;
  logic       valid;
  logic       ack;
  logic       miss;

  modport master (
    input  key_in,
    input  ack,
    output onehot_out,
    output valid,
    output miss
  );

  modport slave (
    output key_in,
    output ack,
    input  onehot_out,
    input  valid,
    input  miss
  );
endinterface

// File: rtl/onehot_request_latch.sv
// rtl/onehot_request_latch.sv - debounced eight-key front end holding a lowest-index one-hot request
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    onehot_request_latch_if.master (key_in, ack in; onehot_out, valid, miss out)
// Parameters:
//   DEBOUNCE_CYCLES  edges a line must hold a new level before its debounced state follows (1..255)
//   CNT_W            per-line counter width, derived from DEBOUNCE_CYCLES
// Build option:
//   ONEHOT_REQ_SYNC_EN  when defined, each key line passes a 2-flop synchronizer before debounce
module onehot_request_latch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  onehot_request_latch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Sampled key lines feeding the debouncers.
  logic [7:0] s;

`ifdef ONEHOT_REQ_SYNC_EN
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.key_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  assign s = bus.key_in;
`endif

  // Debounce: a line's counter runs only while its sample disagrees with
  // the debounced level; any agreeing sample restarts the count.
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [7:0]       db_q, db_d;
  logic [7:0]       db_prev_q, db_prev_d;

  always_comb begin
    db_d      = db_q;
    db_prev_d = db_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (s[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
      db_q      <= 8'h00;
      db_prev_q <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
    end
  end

  // Request state machine.
  state_t     state_q, state_d;
  logic [7:0] onehot_q, onehot_d;
  logic       valid_q, valid_d;
  logic       miss_q, miss_d;
  logic [7:0] rise;
  logic [7:0] lowest;

  assign rise = db_q & ~db_prev_q;
  // Two's-complement trick isolates the lowest set bit of db.
  assign lowest = db_q & (~db_q + 8'd1);

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    miss_d   = (rise != 8'h00) && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (db_q != 8'h00) begin
          onehot_d = lowest;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (bus.ack) begin
          onehot_d = 8'h00;
          valid_d  = 1'b0;
          state_d  = WAIT_REL;
        end
      end
      WAIT_REL: begin
        // Every key, including losers of a simultaneous press, must be
        // released before another request can be formed.
        if (db_q == 8'h00) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = 8'h00;
        valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      onehot_q <= 8'h00;
      valid_q  <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.onehot_out = onehot_q;
  assign bus.valid      = valid_q;
  assign bus.miss       = miss_q;

endmodule
